beep_sequencer: RTL and testbench

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/beep_pkg.sv | 15 +
 rtl/beep_tone_gen.sv | 44 ++++
 rtl/beep_sequencer.sv | 136 +++++++++++++
 tb/tb_beep_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared state encoding and default field widths for the beep sequencer.
package beep_pkg;

    localparam int unsigned HP_W_DEF    = 15;
    localparam int unsigned T_W_DEF     = 24;
    localparam int unsigned BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave divider: toggles beep every hp cycles while run is high,
// and holds tc/beep cleared whenever run is low.
module beep_tone_gen
    import beep_pkg::*;
#(
    parameter int unsigned HP_W = HP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [HP_W-1:0] hp,
    output logic            beep
);

    logic [HP_W-1:0] tc_q, tc_d;
    logic            beep_q, beep_d;

    always_comb begin
        tc_d   = '0;
        beep_d = 1'b0;
        if (run) begin
            if (tc_q == hp - HP_W'(1)) begin
                tc_d   = '0;
                beep_d = ~beep_q;
            end else begin
                tc_d   = tc_q + HP_W'(1);
                beep_d = beep_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q   <= '0;
            beep_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;

endmodule

// File: rtl/beep_sequencer.sv
// Buzzer cadence sequencer: alternating tone-on and silent phases for a
// configured number of bursts (or continuously) with abort support.
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int unsigned HP_W    = HP_W_DEF,
    parameter int unsigned T_W     = T_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [HP_W-1:0]    half_period,
    input  logic [T_W-1:0]     on_cycles,
    input  logic [T_W-1:0]     off_cycles,
    input  logic [BURST_W-1:0] bursts,
    input  logic               stop,
    output logic               ready,
    output logic               busy,
    output logic               beep,
    output logic               done
);

    state_e             state_q, state_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [T_W-1:0]     on_q, on_d;
    logic [T_W-1:0]     off_q, off_d;
    logic [BURST_W-1:0] bursts_q, bursts_d;
    logic [T_W-1:0]     pc_q, pc_d;
    logic [BURST_W-1:0] bc_q, bc_d;

    logic               on_last, off_last, finish, run;
    logic [BURST_W-1:0] bc_inc;

    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        on_d     = on_q;
        off_d    = off_q;
        bursts_d = bursts_q;
        pc_d     = pc_q;
        bc_d     = bc_q;
        run      = 1'b0;

        on_last  = (pc_q == on_q - T_W'(1));
        off_last = (pc_q == off_q - T_W'(1));
        bc_inc   = (bc_q == '1) ? bc_q : bc_q + BURST_W'(1);
        finish   = (bursts_q != '0) && (bc_inc == bursts_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Zero half-period / on-length are normalised once here.
                    hp_d     = (half_period == '0) ? HP_W'(1) : half_period;
                    on_d     = (on_cycles == '0) ? T_W'(1) : on_cycles;
                    off_d    = off_cycles;
                    bursts_d = bursts;
                    pc_d     = '0;
                    bc_d     = '0;
                    state_d  = ON;
                end
            end
            ON: begin
                if (stop) begin
                    pc_d    = '0;
                    state_d = DONE;
                end else if (on_last) begin
                    // run stays low so the tone divider restarts cleared.
                    pc_d = '0;
                    bc_d = bc_inc;
                    if (finish)
                        state_d = DONE;
                    else if (off_q != '0)
                        state_d = OFF;
                    else
                        state_d = ON;
                end else begin
                    pc_d = pc_q + T_W'(1);
                    run  = 1'b1;
                end
            end
            OFF: begin
                if (stop) begin
                    pc_d    = '0;
                    state_d = DONE;
                end else if (off_last) begin
                    pc_d    = '0;
                    state_d = ON;
                end else begin
                    pc_d = pc_q + T_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hp_q     <= '0;
            on_q     <= '0;
            off_q    <= '0;
            bursts_q <= '0;
            pc_q     <= '0;
            bc_q     <= '0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            on_q     <= on_d;
            off_q    <= off_d;
            bursts_q <= bursts_d;
            pc_q     <= pc_d;
            bc_q     <= bc_d;
        end
    end

    beep_tone_gen #(
        .HP_W (HP_W)
    ) u_tone (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .hp   (hp_q),
        .beep (beep)
    );

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer: directed vector table, hand-written
// cadence scenarios and randomized traffic against an arithmetic timeline model.
module tb_beep_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [14:0] half_period;
    logic [23:0] on_cycles;
    logic [23:0] off_cycles;
    logic [7:0]  bursts;
    logic        ready, busy, beep, done;

    int total = 0;
    int bad   = 0;

    beep_sequencer #(
        .HP_W    (15),
        .T_W     (24),
        .BURST_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .half_period (half_period),
        .on_cycles   (on_cycles),
        .off_cycles  (off_cycles),
        .bursts      (bursts),
        .stop        (stop),
        .ready       (ready),
        .busy        (busy),
        .beep        (beep),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 running, 2 done; m_t = cycles since pattern start.
    int          m_mode = 0;
    int unsigned m_t, m_hp, m_on, m_off, m_b;

    function automatic void model_update();
        int unsigned total_len;
        if (rst) begin
            m_mode = 0;
            m_t    = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_hp   = (half_period == 0) ? 1 : int'(half_period);
                m_on   = (on_cycles == 0) ? 1 : int'(on_cycles);
                m_off  = off_cycles;
                m_b    = bursts;
                m_t    = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            total_len = m_b * m_on + (m_b - 1) * m_off;
            if (stop)
                m_mode = 2;
            else if (m_b != 0 && m_t + 1 == total_len)
                m_mode = 2;
            else
                m_t = m_t + 1;
        end else begin
            m_mode = 0;
        end
    endfunction

    function automatic logic [3:0] model_out();
        int unsigned period, w;
        logic        bp;
        if (m_mode == 0) return 4'b1000;
        if (m_mode == 2) return 4'b0101;
        period = m_on + m_off;
        w      = m_t % period;
        bp     = (w < m_on) && (((w / m_hp) % 2) == 1);
        return {1'b0, 1'b1, bp, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // One clock: model sees the same inputs as the DUT, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        chk("model{rdy,busy,beep,done}", {ready, busy, beep, done}, model_out());
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic [14:0] hp;
        logic [23:0] on;
        logic [23:0] off;
        logic [7:0]  b;
        logic [3:0]  exp;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic p, int hp, int on, int off, int b, logic [3:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p;
        v.hp = 15'(hp); v.on = 24'(on); v.off = 24'(off); v.b = 8'(b);
        v.exp = e;
        return v;
    endfunction

    vec_t vt[16];

    initial begin
        int beep_cycles[8] = '{3, 4, 7, 8, 15, 16, 19, 20};
        logic eb;
        int   ndone;
        logic prev_done;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        half_period = '0; on_cycles = '0; off_cycles = '0; bursts = '0;
        tick();
        chk("reset_state", {ready, busy, beep, done}, 4'b1000);
        rst = 1'b0;

        // exp = {ready, busy, beep, done}
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 4'b1000);
        vt[1]  = mk(0, 1, 0, 0, 0, 0, 3, 4'b0100);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b0101);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b1000);
        vt[6]  = mk(0, 1, 1, 1, 3, 2, 2, 4'b0100);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b0110);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b0100);
        vt[9]  = mk(0, 0, 1, 0, 0, 0, 0, 4'b0101);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 4'b1000);
        vt[11] = mk(0, 0, 1, 0, 0, 0, 0, 4'b1000);
        vt[12] = mk(0, 1, 0, 1, 5, 0, 0, 4'b0100);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 4'b0110);
        vt[14] = mk(1, 0, 0, 0, 0, 0, 0, 4'b1000);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 4'b1000);

        for (int i = 0; i < 16; i++) begin
            rst = vt[i].rst; start = vt[i].start; stop = vt[i].stop;
            half_period = vt[i].hp; on_cycles = vt[i].on;
            off_cycles = vt[i].off; bursts = vt[i].b;
            tick();
            chk($sformatf("vec%0d", i), {ready, busy, beep, done}, vt[i].exp);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;

        // Two-burst cadence, start accepted at edge 0.
        half_period = 15'd2; on_cycles = 24'd8; off_cycles = 24'd4; bursts = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            eb = 1'b0;
            foreach (beep_cycles[j]) if (beep_cycles[j] == c) eb = 1'b1;
            chk($sformatf("cadence_beep_c%0d", c), {3'b0, beep}, {3'b0, eb});
            chk($sformatf("cadence_done_c%0d", c), {3'b0, done}, {3'b0, logic'(c == 21)});
            chk($sformatf("cadence_ready_c%0d", c), {3'b0, ready}, {3'b0, logic'(c == 22)});
            if (c < 22) tick();
        end

        // Continuous mode aborted at cycle 50.
        half_period = 15'd2; on_cycles = 24'd4; off_cycles = 24'd4; bursts = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        chk("cont_busy_c50", {3'b0, busy}, 4'b0001);
        stop = 1'b1;
        tick();
        chk("cont_stop_c51", {ready, busy, beep, done}, 4'b0101);
        stop = 1'b0;
        tick();
        chk("cont_idle_c52", {ready, busy, beep, done}, 4'b1000);

        // start held high: each DONE is followed by one IDLE cycle, then ON.
        half_period = 15'd1; on_cycles = 24'd2; off_cycles = 24'd1; bursts = 8'd2;
        start = 1'b1;
        ndone = 0;
        prev_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (prev_done) chk("held_gap_ready", {3'b0, ready}, 4'b0001);
            if (done) ndone++;
            prev_done = done;
        end
        start = 1'b0;
        chk("held_repeats", {3'b0, logic'(ndone >= 4)}, 4'b0001);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 29) == 0);
            half_period = 15'($urandom_range(0, 3));
            on_cycles   = 24'($urandom_range(0, 6));
            off_cycles  = 24'($urandom_range(0, 4));
            bursts      = 8'($urandom_range(0, 4));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
